// File: rtl/experiment_seq_pkg.sv
// Shared types and default widths for the experiment sequencer.
package experiment_seq_pkg;

   localparam int unsigned CNT_W_DEFAULT  = 32;
   localparam int unsigned SHOT_W_DEFAULT = 8;
   localparam int unsigned FIRE_W         = 16;

   typedef enum logic [3:0] {
      ST_IDLE       = 4'd0,
      ST_ARM        = 4'd1,
      ST_WAIT_READY = 4'd2,
      ST_WAIT_FG    = 4'd3,
      ST_DELAY      = 4'd4,
      ST_FIRE       = 4'd5,
      ST_COOLDOWN   = 4'd6,
      ST_DONE       = 4'd7,
      ST_FAULT      = 4'd8
   } seq_state_t;

   typedef enum logic [1:0] {
      FC_NONE        = 2'd0,
      FC_DET_TIMEOUT = 2'd1,
      FC_FG_TIMEOUT  = 2'd2,
      FC_ABORT       = 2'd3
   } fault_code_t;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable saturating down counter; zero_c flags an expired interval.
module seq_down_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         enable,
   output logic         zero_c
);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (enable && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign zero_c = (count == '0);

endmodule

// File: rtl/experiment_sequencer.sv
// Run sequencer: arms the experiment, waits for detector and fast gate,
// fires a delayed trigger pulse per shot with cooldown, timeouts and abort.
module experiment_sequencer
   import experiment_seq_pkg::*;
#(
   parameter int unsigned CNT_W  = CNT_W_DEFAULT,
   parameter int unsigned SHOT_W = SHOT_W_DEFAULT
) (
   input  logic              clock,
   input  logic              reset_signal,
   input  logic [SHOT_W-1:0] cfg_shots,
   input  logic [CNT_W-1:0]  cfg_delay,
   input  logic [FIRE_W-1:0] cfg_fire_width,
   input  logic [CNT_W-1:0]  cfg_cooldown,
   input  logic [CNT_W-1:0]  cfg_timeout,
   input  logic              run_start,
   input  logic              run_abort,
   input  logic              fg_signal,
   input  logic              detector_ready,
   output logic              exp_start,
   output logic              fire,
   output logic              busy,
   output logic              done,
   output logic              fault,
   output logic [1:0]        fault_code,
   output logic [SHOT_W-1:0] shots_done,
   output logic [3:0]        seq_state
);

   seq_state_t        state, state_d;
   fault_code_t       code_q, code_d;
   logic [SHOT_W-1:0] shots_d;
   logic [SHOT_W-1:0] shots_q;
   logic [CNT_W-1:0]  delay_q, cooldown_q, timeout_q;
   logic [FIRE_W-1:0] width_q;
   logic              fg_prev;
   logic              fg_edge;
   logic              latch_cfg;
   logic              cnt_load;
   logic [CNT_W-1:0]  cnt_value;
   logic              cnt_zero;
   logic              timeout_hit;
   logic [CNT_W-1:0]  to_load, fw_load, dl_load, cd_load;

   // One counter times delay, fire width, cooldown and the wait timeouts.
   seq_down_counter #(.W(CNT_W)) u_cnt (
      .clk        (clock),
      .rst_n      (reset_signal),
      .load       (cnt_load),
      .load_value (cnt_value),
      .enable     (1'b1),
      .zero_c     (cnt_zero)
   );

   assign fg_edge     = fg_signal & ~fg_prev;
   assign timeout_hit = (timeout_q != '0) && cnt_zero;
   assign to_load     = timeout_q - CNT_W'(1);
   assign dl_load     = delay_q - CNT_W'(1);
   assign cd_load     = cooldown_q - CNT_W'(1);
   assign fw_load     = (width_q == '0) ? '0 : CNT_W'(width_q - FIRE_W'(1));

   // Next state, counter control and next values of registered outputs.
   always_comb begin
      state_d   = state;
      code_d    = code_q;
      shots_d   = shots_done;
      latch_cfg = 1'b0;
      cnt_load  = 1'b0;
      cnt_value = '0;

      case (state)
         ST_IDLE, ST_DONE, ST_FAULT: begin
            if (run_start) begin
               state_d   = ST_ARM;
               latch_cfg = 1'b1;
               code_d    = FC_NONE;
               shots_d   = '0;
            end else if (state == ST_DONE) begin
               state_d = ST_IDLE;
            end
         end
         ST_ARM: begin
            if (shots_q == '0) begin
               state_d = ST_DONE;
            end else begin
               state_d   = ST_WAIT_READY;
               cnt_load  = 1'b1;
               cnt_value = to_load;
            end
         end
         ST_WAIT_READY: begin
            if (timeout_hit) begin
               state_d = ST_FAULT;
               code_d  = FC_DET_TIMEOUT;
            end else if (detector_ready) begin
               state_d   = ST_WAIT_FG;
               cnt_load  = 1'b1;
               cnt_value = to_load;
            end
         end
         ST_WAIT_FG: begin
            if (timeout_hit) begin
               state_d = ST_FAULT;
               code_d  = FC_FG_TIMEOUT;
            end else if (fg_edge) begin
               cnt_load = 1'b1;
               if (delay_q == '0) begin
                  state_d   = ST_FIRE;
                  cnt_value = fw_load;
               end else begin
                  state_d   = ST_DELAY;
                  cnt_value = dl_load;
               end
            end
         end
         ST_DELAY: begin
            if (cnt_zero) begin
               state_d   = ST_FIRE;
               cnt_load  = 1'b1;
               cnt_value = fw_load;
            end
         end
         ST_FIRE, ST_COOLDOWN: begin
            if (cnt_zero) begin
               if ((state == ST_FIRE) && (cooldown_q != '0)) begin
                  state_d   = ST_COOLDOWN;
                  cnt_load  = 1'b1;
                  cnt_value = cd_load;
               end else if (shots_done == shots_q) begin
                  state_d = ST_DONE;
               end else begin
                  state_d   = ST_WAIT_READY;
                  cnt_load  = 1'b1;
                  cnt_value = to_load;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Abort overrides any timeout or normal transition.
      if (run_abort && (state inside {ST_ARM, ST_WAIT_READY, ST_WAIT_FG,
                                      ST_DELAY, ST_FIRE, ST_COOLDOWN})) begin
         state_d  = ST_FAULT;
         code_d   = FC_ABORT;
         cnt_load = 1'b0;
      end

      if ((state_d == ST_FIRE) && (state != ST_FIRE)) begin
         shots_d = shots_done + SHOT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_signal) begin
      if (!reset_signal) begin
         state      <= ST_IDLE;
         code_q     <= FC_NONE;
         fg_prev    <= 1'b1;
         exp_start  <= 1'b0;
         fire       <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         fault      <= 1'b0;
         shots_done <= '0;
         shots_q    <= '0;
         delay_q    <= '0;
         width_q    <= '0;
         cooldown_q <= '0;
         timeout_q  <= '0;
      end else begin
         state      <= state_d;
         code_q     <= code_d;
         fg_prev    <= fg_signal;
         exp_start  <= (state_d == ST_ARM);
         fire       <= (state_d == ST_FIRE);
         busy       <= !(state_d inside {ST_IDLE, ST_DONE, ST_FAULT});
         done       <= (state_d == ST_DONE);
         fault      <= (state_d == ST_FAULT);
         shots_done <= shots_d;
         if (latch_cfg) begin
            shots_q    <= cfg_shots;
            delay_q    <= cfg_delay;
            width_q    <= cfg_fire_width;
            cooldown_q <= cfg_cooldown;
            timeout_q  <= cfg_timeout;
         end
      end
   end

   assign fault_code = code_q;
   assign seq_state  = state;

endmodule

// File: tb/tb_experiment_sequencer.sv
// Directed bench for experiment_sequencer with a fire-pulse scoreboard.
module tb_experiment_sequencer;

   typedef struct {
      int rise;
      int width;
   } exp_t;

   logic        clock;
   logic        reset_signal;
   logic [7:0]  cfg_shots;
   logic [31:0] cfg_delay;
   logic [15:0] cfg_fire_width;
   logic [31:0] cfg_cooldown;
   logic [31:0] cfg_timeout;
   logic        run_start;
   logic        run_abort;
   logic        fg_signal;
   logic        detector_ready;
   logic        exp_start;
   logic        fire;
   logic        busy;
   logic        done;
   logic        fault;
   logic [1:0]  fault_code;
   logic [7:0]  shots_done;
   logic [3:0]  seq_state;

   exp_t sb[$];
   int   checks    = 0;
   int   failures  = 0;
   int   cyc       = 0;
   int   rises     = 0;
   int   done_cnt  = 0;
   int   fire_len  = 0;
   int   rise_cyc  = 0;
   bit   fire_prev = 0;

   experiment_sequencer dut (
      .clock          (clock),
      .reset_signal   (reset_signal),
      .cfg_shots      (cfg_shots),
      .cfg_delay      (cfg_delay),
      .cfg_fire_width (cfg_fire_width),
      .cfg_cooldown   (cfg_cooldown),
      .cfg_timeout    (cfg_timeout),
      .run_start      (run_start),
      .run_abort      (run_abort),
      .fg_signal      (fg_signal),
      .detector_ready (detector_ready),
      .exp_start      (exp_start),
      .fire           (fire),
      .busy           (busy),
      .done           (done),
      .fault          (fault),
      .fault_code     (fault_code),
      .shots_done     (shots_done),
      .seq_state      (seq_state)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Advance one cycle and score any completed fire pulse.
   task automatic tick();
      exp_t e;
      @(posedge clock);
      #1;
      cyc++;
      if (fire === 1'b1 && !fire_prev) begin
         rises++;
         fire_len = 0;
         rise_cyc = cyc;
         check("fire_expected", 32'(sb.size() != 0), 1);
      end
      if (fire === 1'b1) fire_len++;
      if (fire !== 1'b1 && fire_prev) begin
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("fire_rise_cycle", rise_cyc, e.rise);
            check("fire_width", fire_len, e.width);
         end
      end
      if (done === 1'b1) done_cnt++;
      fire_prev = (fire === 1'b1);
   endtask

   task automatic start_run(input int shots, input int delay, input int width,
                            input int cool, input int tmo);
      cfg_shots      = 8'(shots);
      cfg_delay      = 32'(delay);
      cfg_fire_width = 16'(width);
      cfg_cooldown   = 32'(cool);
      cfg_timeout    = 32'(tmo);
      run_start      = 1'b1;
      tick();
      run_start      = 1'b0;
      check("arm_state", seq_state, 1);
      check("arm_exp_start", exp_start, 1);
      check("arm_fault_clear", fault, 0);
   endtask

   // Single-cycle fast-gate pulse; expected fire pushed to the scoreboard.
   task automatic fg_edge(input int delay, input int exp_width);
      fg_signal = 1'b1;
      sb.push_back('{cyc + 1 + delay, exp_width});
      tick();
      fg_signal = 1'b0;
   endtask

   task automatic wait_state(input logic [3:0] s, input int budget, input string tag);
      int n = 0;
      while (seq_state !== s && n < budget) begin
         tick();
         n++;
      end
      check(tag, seq_state, s);
   endtask

   task automatic measure_timeout(input logic [3:0] s, input int interval,
                                  input int code, input string tag);
      int n = 0;
      int entry;
      while (seq_state !== s && n < 10) begin
         tick();
         n++;
      end
      entry = cyc;
      n = 0;
      while (fault !== 1'b1 && n < 300) begin
         tick();
         n++;
      end
      check({tag, "_interval"}, cyc - entry, interval);
      check({tag, "_code"}, fault_code, code);
   endtask

   initial begin
      int d0;
      int r0;
      int n;
      reset_signal   = 1'b0;
      cfg_shots      = '0;
      cfg_delay      = '0;
      cfg_fire_width = '0;
      cfg_cooldown   = '0;
      cfg_timeout    = '0;
      run_start      = 1'b0;
      run_abort      = 1'b0;
      fg_signal      = 1'b0;
      detector_ready = 1'b0;
      #2;
      check("reset_outputs", {exp_start, fire, busy, done, fault, fault_code,
                              shots_done, seq_state}, 0);
      tick();
      tick();
      reset_signal = 1'b1;
      tick();
      check("idle_after_reset", seq_state, 0);

      // Three shots, delay 5, width 2, cooldown 10, fast gate every 40 cycles.
      detector_ready = 1'b1;
      d0 = done_cnt;
      r0 = rises;
      start_run(3, 5, 2, 10, 0);
      for (int s = 0; s < 3; s++) begin
         repeat (19) tick();
         fg_edge(5, 2);
         repeat (20) tick();
      end
      wait_state(4'd0, 50, "main_idle");
      check("main_done_pulses", done_cnt - d0, 1);
      check("main_fire_pulses", rises - r0, 3);
      check("main_shots_done", shots_done, 3);

      // Zero delay and zero width: one-cycle fire right after the edge.
      d0 = done_cnt;
      start_run(1, 0, 0, 0, 0);
      repeat (3) tick();
      fg_edge(0, 1);
      wait_state(4'd0, 20, "min_idle");
      check("min_shots_done", shots_done, 1);
      check("min_done_pulses", done_cnt - d0, 1);

      // Zero shots go straight to DONE.
      r0 = rises;
      start_run(0, 3, 3, 3, 0);
      tick();
      check("zero_shots_done", done, 1);
      check("zero_shots_state", seq_state, 7);
      tick();
      check("zero_shots_idle", seq_state, 0);
      check("zero_shots_no_fire", rises - r0, 0);

      // Detector never ready: timeout code 1 after 100 cycles.
      detector_ready = 1'b0;
      r0 = rises;
      start_run(1, 5, 2, 0, 100);
      measure_timeout(4'd2, 100, 1, "det_timeout");
      check("det_timeout_no_fire", rises - r0, 0);
      check("det_timeout_busy", busy, 0);

      // Detector ready but no fast gate: timeout code 2.
      detector_ready = 1'b1;
      start_run(1, 5, 2, 0, 30);
      measure_timeout(4'd3, 30, 2, "fg_timeout");

      // Abort in the third cycle of a 5-cycle fire.
      start_run(2, 2, 5, 0, 0);
      repeat (3) tick();
      fg_edge(2, 3);
      n = 0;
      while (!(fire === 1'b1 && fire_len == 3) && n < 20) begin
         tick();
         n++;
      end
      run_abort = 1'b1;
      tick();
      run_abort = 1'b0;
      check("abort_fire_low", fire, 0);
      check("abort_fault", fault, 1);
      check("abort_code", fault_code, 3);
      check("abort_shots_done", shots_done, 1);

      // Reset during FIRE clears fire without a clock edge.
      start_run(1, 0, 2, 0, 0);
      repeat (3) tick();
      fg_edge(0, 2);
      n = 0;
      while (!(fire === 1'b1 && fire_len == 2) && n < 20) begin
         tick();
         n++;
      end
      #1;
      reset_signal = 1'b0;
      fg_signal    = 1'b1;
      #1;
      check("async_reset_fire", fire, 0);
      check("async_reset_state", seq_state, 0);
      tick();
      tick();
      reset_signal = 1'b1;

      // Fast gate high across reset release is not an edge.
      r0 = rises;
      start_run(1, 1, 1, 0, 0);
      repeat (30) tick();
      check("fg_high_waiting", seq_state, 3);
      check("fg_high_no_fire", rises - r0, 0);
      fg_signal = 1'b0;
      tick();
      fg_edge(1, 1);
      wait_state(4'd0, 20, "fg_high_idle");
      check("fg_high_one_fire", rises - r0, 1);

      // Restart request and config changes mid-run are ignored.
      d0 = done_cnt;
      start_run(2, 3, 2, 4, 0);
      repeat (2) tick();
      cfg_shots      = 8'd5;
      cfg_delay      = 32'd0;
      cfg_fire_width = 16'd7;
      cfg_cooldown   = 32'd0;
      run_start      = 1'b1;
      tick();
      run_start      = 1'b0;
      check("restart_ignored_state", seq_state, 3);
      check("restart_no_exp_start", exp_start, 0);
      repeat (3) tick();
      fg_edge(3, 2);
      repeat (15) tick();
      fg_edge(3, 2);
      wait_state(4'd0, 40, "restart_idle");
      check("restart_shots_done", shots_done, 2);
      check("restart_done_pulses", done_cnt - d0, 1);

      check("scoreboard_empty", 32'(sb.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/experiment_sequencer.md
EXPERIMENT_SEQUENCER -- requirements
Module: experiment_sequencer

Interface
REQ-001 Parameter CNT_W, default 32, width of the delay, cooldown and timeout counters.
REQ-002 Parameter SHOT_W, default 8, width of the shot counter.
REQ-003 clock  in  1  system clock; all logic on its rising edge.
REQ-004 reset_signal  in  1  asynchronous, active-low reset.
REQ-005 cfg_shots  in  SHOT_W  shots per run.
REQ-006 cfg_delay  in  CNT_W  cycles from detected fast-gate edge to fire.
REQ-007 cfg_fire_width  in  16  fire pulse width in cycles; 0 is treated as 1.
REQ-008 cfg_cooldown  in  CNT_W  dead time after each fire, in cycles.
REQ-009 cfg_timeout  in  CNT_W  wait limit in WAIT_READY/WAIT_FG; 0 disables the timeout.
REQ-010 run_start  in  1  one-cycle request to start a run.
REQ-011 run_abort  in  1  one-cycle request to abort the current run.
REQ-012 fg_signal  in  1  fast-gate level, already synchronous to clock.
REQ-013 detector_ready  in  1  detector ready level, synchronous.
REQ-014 exp_start  out  1  one-cycle start pulse to the experiment FSM.
REQ-015 fire  out  1  trigger pulse.
REQ-016 busy  out  1  high in every state except IDLE, DONE and FAULT.
REQ-017 done  out  1  one-cycle pulse at the end of a completed run.
REQ-018 fault  out  1  sticky error flag.
REQ-019 fault_code  out  2  error cause: 0 none, 1 detector timeout, 2 fast-gate timeout, 3 abort.
REQ-020 shots_done  out  SHOT_W  number of shots fired in the current run.
REQ-021 seq_state  out  4  current state encoding, for debug.

Function
REQ-022 States and encodings: IDLE 0, ARM 1, WAIT_READY 2, WAIT_FG 3, DELAY 4, FIRE 5, COOLDOWN 6, DONE 7, FAULT 8.
REQ-023 run_start in IDLE, DONE or FAULT:
- latches all cfg_* inputs; later input changes are ignored until the next run;
- clears fault, fault_code and shots_done;
- moves to ARM.
REQ-024 run_start while busy is ignored.
REQ-025 ARM lasts exactly one cycle with exp_start=1, then moves to WAIT_READY.
REQ-026 cfg_shots=0: the run goes ARM -> DONE; fire is never asserted.
REQ-027 WAIT_READY exits to WAIT_FG on the first cycle detector_ready=1.
REQ-028 Fast-gate edge = fg_signal high in this cycle and low in the previous cycle, using a registered previous value.
REQ-029 WAIT_FG ignores edges that occur in any other state.
REQ-030 On a fast-gate edge in cycle N, fire rises at cycle N+1+cfg_delay.
- cfg_delay=0: WAIT_FG -> FIRE directly.
REQ-031 fire stays high for exactly max(cfg_fire_width,1) cycles.
REQ-032 shots_done increments on the first FIRE cycle.
REQ-033 COOLDOWN lasts cfg_cooldown cycles; 0 skips it.
REQ-034 After cooldown: if shots_done==cfg_shots, go to DONE; otherwise go to WAIT_READY.
REQ-035 DONE lasts one cycle with done=1, then moves to IDLE.
REQ-036 Timeout counter:
- restarts on entry to WAIT_READY and on entry to WAIT_FG;
- after cfg_timeout cycles in the state, go to FAULT with code 1 (WAIT_READY) or 2 (WAIT_FG).
REQ-037 run_abort in any busy state moves to FAULT with code 3; fire drops on the next edge.
REQ-038 Priority within one cycle: abort > timeout > normal transition.
REQ-039 FAULT holds fault=1 until a new run_start.
REQ-040 shots_done wraps modulo 2^SHOT_W only if cfg_shots=2^SHOT_W-1 and another shot is requested; by construction this cannot occur.

Reset
REQ-041 While reset_signal=0, asynchronously:
- state=IDLE;
- all outputs 0;
- latched config 0;
- counters 0;
- fg previous-value register = 1, so a high fast gate at reset release is not an edge.
REQ-042 A reset asserted mid-FIRE drops fire immediately, without waiting for a clock edge.

Structure
REQ-043 Package experiment_seq_pkg SHALL hold:
- the state enum;
- the fault-code enum;
- the CNT_W and SHOT_W defaults.
REQ-044 Delay, fire width, cooldown and timeout SHALL share one instance of the sub-module seq_down_counter (load, enable, zero flag).

Verification
REQ-045 cfg_shots=3, delay=5, width=2, cooldown=10, fast gate with a 40-cycle period, detector ready:
- 3 fire pulses, each 2 cycles wide, each starting 6 cycles after a fast-gate edge;
- done pulses once; shots_done=3.
REQ-046 cfg_delay=0, width=0: fire is a single cycle, one cycle after the fast-gate edge.
REQ-047 detector_ready held 0, timeout=100: fault=1, code=1 exactly 100 cycles after WAIT_READY entry; fire never asserted.
REQ-048 run_abort during the 3rd fire cycle of width=5: fire low next cycle; fault code 3; shots_done unchanged.
REQ-049 fg_signal high at reset release and held high: no fire until a low-to-high transition occurs.
REQ-050 run_start repeated while busy, and cfg changed mid-run: no effect on the run in progress.
